// File: rtl/seg_readback.sv
// Recovers BCD digits from a multiplexed 7-segment bus by debouncing word/select and matching codes.
// Optional SEG_DP_IGNORE_EN: mask the decimal point (bit 7) before matching and candidate compare.
module seg_readback #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            word_in,
  input  logic [DIGITS-1:0]     sel,
  input  logic                  valid,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  frame_done,
  output logic                  err,
  output logic [2:0]            err_pos
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Shared segment codes n0..n9 (active-high, bit 0 = segment a, bit 7 = dp)
  localparam logic [7:0] N0 = 8'h3F;
  localparam logic [7:0] N1 = 8'h06;
  localparam logic [7:0] N2 = 8'h5B;
  localparam logic [7:0] N3 = 8'h4F;
  localparam logic [7:0] N4 = 8'h66;
  localparam logic [7:0] N5 = 8'h6D;
  localparam logic [7:0] N6 = 8'h7D;
  localparam logic [7:0] N7 = 8'h07;
  localparam logic [7:0] N8 = 8'h7F;
  localparam logic [7:0] N9 = 8'h6F;
  localparam logic [9:0][7:0] SEG_CODES = {N9, N8, N7, N6, N5, N4, N3, N2, N1, N0};

`ifdef SEG_DP_IGNORE_EN
  localparam logic [7:0] DP_MASK = 8'h7F;
`else
  localparam logic [7:0] DP_MASK = 8'hFF;
`endif

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  logic [1:0]                r_state;
  logic [7:0]                r_cnt;
  logic [7:0]                r_cand_word;
  logic [DIGITS-1:0]         r_cand_sel;
  logic [DIGITS-1:0]         r_seen;
  logic [DIGITS-1:0][3:0]    r_digits;
  logic                      r_pend;
  logic                      r_frame_done;
  logic                      r_err;
  logic [2:0]                r_err_pos;

  logic                      w_legal;
  logic                      w_same;
  logic [2:0]                w_idx;
  logic                      w_hit;
  logic [3:0]                w_digit;
  logic [DIGITS-1:0]         w_seen_nx;

  assign w_legal   = valid && $onehot(sel);
  assign w_same    = ((word_in & DP_MASK) == (r_cand_word & DP_MASK)) && (sel == r_cand_sel);
  assign w_seen_nx = r_seen | r_cand_sel;

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < DIGITS; i++)
      if (r_cand_sel[i]) w_idx = 3'(i);
  end

  always_comb begin
    w_hit   = 1'b0;
    w_digit = 4'hF;
    for (int k = 0; k < 10; k++)
      if ((r_cand_word & DP_MASK) == (SEG_CODES[k] & DP_MASK)) begin
        w_hit   = 1'b1;
        w_digit = 4'(k);
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_cand_word  <= 8'd0;
      r_cand_sel   <= '0;
      r_seen       <= '0;
      r_digits     <= '1;
      r_pend       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_pend;
      r_pend       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_cand_word <= word_in;
            r_cand_sel  <= sel;
            r_cnt       <= 8'd1;
            r_state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!w_legal) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end else if (w_same) begin
            // cnt stays below STABLE_CYCLES here, so the increment cannot wrap
            if (r_cnt + 8'd1 >= STABLE_W) begin
              r_cnt   <= STABLE_W;
              r_state <= S_COMMIT;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            r_cand_word <= word_in;
            r_cand_sel  <= sel;
            r_cnt       <= 8'd1;
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < DIGITS; i++)
            if (r_cand_sel[i]) r_digits[i] <= w_digit;
          if (&w_seen_nx) begin
            r_seen <= '0;
            r_pend <= 1'b1;
          end else begin
            r_seen <= w_seen_nx;
          end
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A miss committed on the same edge as err_clr keeps the error set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_pos <= 3'd0;
    end else if (r_state == S_COMMIT && !w_hit) begin
      r_err     <= 1'b1;
      r_err_pos <= w_idx;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign digits_out = r_digits;
  assign frame_done = r_frame_done;
  assign err        = r_err;
  assign err_pos    = r_err_pos;

endmodule

// File: tb/tb_seg_readback.sv
// Bench for seg_readback: directed test-plan steps plus random bursts against a run-length reference model.
module tb_seg_readback;
  localparam int D = 4;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     word_in;
  logic [D-1:0]   sel;
  logic           valid;
  logic           err_clr;
  logic [4*D-1:0] digits_out;
  logic           frame_done;
  logic           err;
  logic [2:0]     err_pos;

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
`ifdef SEG_DP_IGNORE_EN
  logic [7:0] mask = 8'h7F;
`else
  logic [7:0] mask = 8'hFF;
`endif

  // reference model: length of the current run of identical legal samples
  int         m_run;
  logic [7:0] m_cw;
  logic [D-1:0] m_cs;
  bit         m_commit;
  logic [3:0] m_dig [D];
  bit         m_seen [D];
  bit         m_pend, m_fd, m_err;
  logic [2:0] m_epos;

  always #5 clk = ~clk;

  seg_readback #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .sel(sel), .valid(valid),
    .err_clr(err_clr), .digits_out(digits_out), .frame_done(frame_done),
    .err(err), .err_pos(err_pos)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pos_of(input logic [D-1:0] s);
    int n = 0, p = -1;
    for (int i = 0; i < D; i++) if (s[i]) begin n++; p = i; end
    return (n == 1) ? p : -1;
  endfunction

  function automatic logic [3:0] decode(input logic [7:0] w);
    for (int k = 0; k < 10; k++) if ((w & mask) == (seg_tab[k] & mask)) return 4'(k);
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_run = 0; m_commit = 0; m_cw = '0; m_cs = '0;
    m_pend = 0; m_fd = 0; m_err = 0; m_epos = 0;
    for (int i = 0; i < D; i++) begin m_dig[i] = 4'hF; m_seen[i] = 0; end
  endtask

  task automatic model_edge();
    bit all;
    m_fd = m_pend; m_pend = 0;
    if (m_commit) begin
      int p = pos_of(m_cs);
      logic [3:0] d = decode(m_cw);
      m_dig[p] = d; m_seen[p] = 1;
      all = 1;
      for (int i = 0; i < D; i++) all &= m_seen[i];
      if (all) begin
        m_pend = 1;
        for (int i = 0; i < D; i++) m_seen[i] = 0;
      end
      if (d == 4'hF) begin m_err = 1; m_epos = 3'(p); end
      else if (err_clr) m_err = 0;
      m_commit = 0; m_run = 0;
    end else begin
      if (err_clr) m_err = 0;
      if (valid && pos_of(sel) >= 0) begin
        if (m_run > 0 && sel == m_cs && (word_in & mask) == (m_cw & mask)) m_run++;
        else begin m_run = 1; m_cw = word_in; m_cs = sel; end
        if (m_run == S) m_commit = 1;
      end else m_run = 0;
    end
  endtask

  task automatic compare(input string tag);
    logic [4*D-1:0] ed;
    for (int i = 0; i < D; i++) ed[4*i +: 4] = m_dig[i];
    chk({tag, ".digits"}, 32'(digits_out), 32'(ed));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_fd));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".err_pos"}, 32'(err_pos), 32'(m_epos));
  endtask

  task automatic step(input string tag, input logic v, input logic [D-1:0] s,
                      input logic [7:0] w, input logic c);
    @(negedge clk);
    valid = v; sel = s; word_in = w; err_clr = c;
    @(posedge clk);
    model_edge();
    #1 compare(tag);
  endtask

  task automatic hold(input string tag, input int n, input logic [D-1:0] s,
                      input logic [7:0] w);
    for (int i = 0; i < n; i++) step(tag, 1'b1, s, w, 1'b0);
  endtask

  initial begin
    rst = 1'b1; valid = 0; sel = '0; word_in = '0; err_clr = 0;
    model_reset();
    #12;
    compare("reset");
    @(negedge clk) rst = 1'b0;

    hold("n7_pos0", 4, 4'b0001, seg_tab[7]);
    chk("n7_slot", 32'(digits_out), 32'h0000FFF7);

    for (int p = 0; p < 4; p++) hold("frame", 4, 4'(1 << p), seg_tab[p + 1]);
    chk("frame_digits", 32'(digits_out), 32'h00004321);
    step("frame_pulse", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("frame_pulse_hi", 32'(frame_done), 32'd1);
    step("frame_after", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("frame_pulse_lo", 32'(frame_done), 32'd0);

    for (int i = 0; i < 6; i++) hold("toggle", 2, 4'b0010, seg_tab[i % 2 ? 9 : 6]);
    chk("toggle_nocommit", 32'(digits_out), 32'h00004321);
    hold("n5_pos1", 4, 4'b0010, seg_tab[5]);
    chk("n5_slot", 32'(digits_out), 32'h00004351);

    hold("miss_pos2", 4, 4'b0100, 8'h00);
    chk("miss_err", 32'(err), 32'd1);
    chk("miss_pos", 32'(err_pos), 32'd2);
    step("clr", 1'b0, 4'b0000, 8'h00, 1'b1);
    chk("clr_err", 32'(err), 32'd0);
    hold("miss_clr", 3, 4'b1000, 8'hFF);
    step("miss_clr_edge", 1'b1, 4'b1000, 8'hFF, 1'b1);
    chk("miss_wins", 32'(err), 32'd1);
    chk("miss_wins_pos", 32'(err_pos), 32'd3);

    hold("multi", 2, 4'b0001, seg_tab[2]);
    step("multi_sel", 1'b1, 4'b0011, seg_tab[2], 1'b0);
    step("multi_idle", 1'b1, 4'b0001, seg_tab[2], 1'b0);
    step("drop", 1'b0, 4'b0001, seg_tab[2], 1'b0);
    step("drop_idle", 1'b0, 4'b0001, seg_tab[2], 1'b0);
    chk("illegal_nowrite", 32'(digits_out[3:0]), 32'h1);

    hold("pre_rst", 2, 4'b0001, seg_tab[6]);
    @(negedge clk) rst = 1'b1;
    model_reset();
    #1 compare("async_rst");
    chk("async_rst_digits", 32'(digits_out), 32'h0000FFFF);
    @(negedge clk) rst = 1'b0;

    hold("dp_n8", 4, 4'b0001, seg_tab[8] | 8'h80);
`ifdef SEG_DP_IGNORE_EN
    chk("dp_slot", 32'(digits_out[3:0]), 32'h8);
    chk("dp_err", 32'(err), 32'd0);
`else
    chk("dp_slot", 32'(digits_out[3:0]), 32'hF);
    chk("dp_err", 32'(err), 32'd1);
`endif

    for (int b = 0; b < 150; b++) begin
      logic [D-1:0] s;
      logic [7:0]   w;
      int r = $urandom_range(0, 9);
      int q = $urandom_range(0, 9);
      int len = $urandom_range(1, 5);
      s = (r == 0) ? '0 : (r == 1) ? 4'($urandom) : 4'(1 << $urandom_range(0, D - 1));
      w = seg_tab[$urandom_range(0, 9)];
      if (q == 7) w = w | 8'h80;
      else if (q >= 8) w = 8'($urandom);
      for (int i = 0; i < len; i++)
        step("rand", 1'($urandom_range(0, 15) != 0), s, w, 1'($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/seg_readback.md
# seg_readback

Recovers BCD digits from the multiplexed 7-segment bus: it is the inverse of the digit-to-segment decode stage. It samples the segment word and one-hot position select driven toward the display, and waits for the pair to stay stable for a programmable number of cycles. It then maps the word back to a 4-bit digit using the shared `n0`..`n9` segment codes from macros.v and stores it per position. It sits beside the display driver for self-test and readback of the oven timer display, flagging any non-digit pattern.

## Interface
- DIGITS, 4, number of multiplexed display positions (1..8)
- STABLE_CYCLES, 3, consecutive identical valid samples required before commit (2..255)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- word_in  input  8  segment word on the display bus; bit 7 is the decimal point
- sel  input  DIGITS  one-hot position select; bit i = position i
- valid  input  1  word_in/sel qualify this cycle
- err_clr  input  1  clears sticky error
- digits_out  output  4*DIGITS  position i in bits [4i+3:4i]; 0..9, or 4'hF = unknown/invalid
- frame_done  output  1  one-cycle pulse when every position has been committed since the last pulse
- err  output  1  sticky: a committed word matched no digit code
- err_pos  output  3  position index of the most recent error

## Operation
- Matching: word_in (masked per Configuration) compared with `n0`..`n9`. On a hit, digit = index. On a miss, digit = 4'hF and error.
- A sample is legal when valid=1 and sel has exactly one bit set. Zero or multiple set bits make the sample illegal.
- State IDLE: on a legal sample, capture cand_word and cand_sel, set cnt=1, go to SETTLE. Otherwise stay.
- State SETTLE:
  - Legal sample with word and sel equal to the candidate: cnt++. When cnt reaches STABLE_CYCLES, go to COMMIT.
  - Legal sample that differs: recapture the candidate, cnt=1, stay in SETTLE.
  - Illegal sample: go to IDLE.
- State COMMIT (exactly one cycle, inputs ignored):
  - Write the digit to the slot given by the sel index.
  - Set that position's seen bit.
  - On a miss, set err=1 and err_pos=index.
  - If all seen bits are then set, pulse frame_done on the next cycle and clear all seen bits.
  - Return to IDLE.
- The same position may be recommitted repeatedly. The slot is rewritten, and frame_done still requires all positions.
- err_clr clears err in the cycle it is sampled. If a COMMIT miss lands on the same edge, the new error wins (err=1).
- Reset mid-operation: everything returns to reset values immediately, including seen bits and the candidate.

## Timing
- Reset values:
  - digits_out = all 4'hF
  - frame_done = 0, err = 0, err_pos = 0
  - state IDLE, cnt = 0, seen = 0
- Latency: with an unchanging legal word/sel first sampled at edge E0, the FSM enters COMMIT at edge E(STABLE_CYCLES-1). digits_out updates at edge E(STABLE_CYCLES). With the default this is E3.
- frame_done is high for the one cycle following the final COMMIT edge (registered, E(STABLE_CYCLES+1)).
- err and err_pos update on the same edge as digits_out.
- cnt is 8 bits and saturates at STABLE_CYCLES; it cannot wrap.

## Configuration
- SEG_DP_IGNORE_EN
  - Defined: bit 7 of word_in and of the `nX` codes is masked before comparison, so a lit decimal point still decodes. The candidate-equality check also ignores bit 7.
  - Undefined: all 8 bits must match exactly; a set decimal point on a digit yields a miss and an error.

## Test plan
- Reset, then word_in=`n7`, sel=4'b0001, valid=1 held -> digits_out[3:0]=4'h7 after edge E3, other slots remain 4'hF, err=0.
- Cycle `n1`,`n2`,`n3`,`n4` on positions 0..3, each held 4 cycles -> digits_out=16'h4321, frame_done one-cycle pulse after position 3 commits, no second pulse.
- Word changes every 2 cycles on position 1 (STABLE_CYCLES=3) -> no commit, digits_out unchanged. Then hold `n5` -> slot 1 = 4'h5.
- word_in=8'h00 held on position 2 -> slot 2 = 4'hF, err=1, err_pos=2. Then err_clr pulse -> err=0. Then err_clr asserted on the same edge as a new miss commit -> err=1.
- sel=4'b0011 or valid dropped during SETTLE -> FSM back to IDLE, no write. Assert rst mid-SETTLE -> all outputs at reset values asynchronously.
- `n8` with bit 7 set on position 0 -> with SEG_DP_IGNORE_EN slot 0 = 4'h8, err=0. Without the macro slot 0 = 4'hF, err=1.
